multipoint_rr_arbiter: RTL and testbench

- Parametrised successor to the fixed 8-node / 4-channel nested-loop arbiter for the multipoint interposer.
- Each of N_NODES nodes may request any subset of N_CHAN shared interposer channels.
- Per channel, the block grants one owner using round-robin priority, holds ownership across consecutive cycles up to a burst limit, and guarantees no node owns two channels in the same cycle.
- Outputs are registered per-channel control words driving the channel muxes, plus per-node grant flags.

---
 rtl/multipoint_rr_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_multipoint_rr_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multipoint_rr_arbiter.sv
// multipoint_rr_arbiter
// Per-channel round-robin arbiter for the multipoint interposer. N_NODES nodes
// may request any subset of N_CHAN shared channels. A busy channel keeps its
// owner for at most MAX_HOLD consecutive cycles while another node contends.
// Free channels are then allocated in ascending channel order. A node never
// owns more than one channel in the same cycle. All outputs are registered.
module multipoint_rr_arbiter #(
  parameter  int N_NODES  = 8,
  parameter  int N_CHAN   = 4,
  parameter  int MAX_HOLD = 4,
  localparam int ID_W     = $clog2(N_NODES)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [N_NODES*N_CHAN-1:0]    request_port,
  output logic [N_CHAN*(ID_W+1)-1:0]   control_port,
  output logic [N_NODES*N_CHAN-1:0]    grant_port
);

  // Width of one control field: {valid, owner_id}.
  localparam int CW   = ID_W + 1;
  // The hold counter only has to reach MAX_HOLD-1. It is at least one bit wide.
  localparam int HC_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

  localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(MAX_HOLD - 1);
  localparam logic [HC_W-1:0] HOLD_ONE  = HC_W'(1);
  localparam logic [ID_W-1:0] ID_LAST   = ID_W'(N_NODES - 1);
  localparam logic [ID_W-1:0] ID_ONE    = ID_W'(1);
  localparam logic [ID_W:0]   N_NODES_X = (ID_W + 1)'(N_NODES);

  // Per-channel state.
  // An IDLE channel has valid_q=0, and its owner_q is kept at zero.
  logic [N_CHAN-1:0] valid_q;
  logic [N_CHAN-1:0] valid_d;
  logic [ID_W-1:0]   owner_q [N_CHAN];
  logic [ID_W-1:0]   owner_d [N_CHAN];
  logic [HC_W-1:0]   hold_q  [N_CHAN];
  logic [HC_W-1:0]   hold_d  [N_CHAN];
  logic [ID_W-1:0]   rr_q    [N_CHAN];
  logic [ID_W-1:0]   rr_d    [N_CHAN];

  // Registered outputs.
  logic [N_CHAN*CW-1:0]      control_q;
  logic [N_CHAN*CW-1:0]      control_d;
  logic [N_NODES*N_CHAN-1:0] grant_q;
  logic [N_NODES*N_CHAN-1:0] grant_d;

  // Intermediate results of the arbitration phases.
  logic [N_NODES-1:0] req_by_chan_s [N_CHAN];
  logic [N_CHAN-1:0]  retain_s;
  logic [N_CHAN-1:0]  expire_s;
  logic [N_NODES-1:0] retained_node_s;

  // Regroup the flat request vector so that each channel sees a bitmap of its requesters.
  always_comb begin
    for (int c = 0; c < N_CHAN; c++) begin
      req_by_chan_s[c] = '0;
      for (int n = 0; n < N_NODES; n++) begin
        req_by_chan_s[c][n] = request_port[n*N_CHAN + c];
      end
    end
  end

  // Retain phase: decide for each busy channel whether its owner keeps it, and mark expiries at the hold limit.
  always_comb begin
    logic               own_req;
    logic               rival_req;
    logic               keep;
    logic [N_NODES-1:0] kept_nodes;
    own_req    = 1'b0;
    rival_req  = 1'b0;
    keep       = 1'b0;
    kept_nodes = '0;
    retain_s   = '0;
    expire_s   = '0;
    for (int c = 0; c < N_CHAN; c++) begin
      own_req   = req_by_chan_s[c][owner_q[c]];
      rival_req = 1'b0;
      for (int n = 0; n < N_NODES; n++) begin
        rival_req = rival_req | (req_by_chan_s[c][n] & (owner_q[c] != ID_W'(n)));
      end
      // The owner keeps the channel while below the limit, or indefinitely when nobody else asks.
      keep        = valid_q[c] & own_req & ((hold_q[c] < HOLD_LAST) | ~rival_req);
      retain_s[c] = keep;
      // The owner still wants the channel but must yield it. It may not win this channel back in this cycle.
      expire_s[c] = valid_q[c] & own_req & ~keep;
      for (int n = 0; n < N_NODES; n++) begin
        kept_nodes[n] = kept_nodes[n] | (keep & (owner_q[c] == ID_W'(n)));
      end
    end
    retained_node_s = kept_nodes;
  end

  // Allocate phase: free channels, taken in ascending order, pick the next eligible node from their rr pointer.
  always_comb begin
    logic [N_NODES-1:0] taken;
    logic               found;
    logic               cand;
    logic [ID_W-1:0]    win;
    logic [ID_W:0]      idx_w;
    logic [ID_W-1:0]    idx;
    // Retained owners are unavailable to every channel in this cycle.
    taken   = retained_node_s;
    found   = 1'b0;
    cand    = 1'b0;
    win     = '0;
    idx_w   = '0;
    idx     = '0;
    valid_d = '0;
    for (int c = 0; c < N_CHAN; c++) begin
      owner_d[c] = '0;
      hold_d[c]  = '0;
      rr_d[c]    = rr_q[c];
    end
    for (int c = 0; c < N_CHAN; c++) begin
      if (retain_s[c]) begin
        valid_d[c] = 1'b1;
        owner_d[c] = owner_q[c];
        // When the sole requester is at the limit, a new tenure window starts.
        hold_d[c]  = (hold_q[c] < HOLD_LAST) ? (hold_q[c] + HOLD_ONE) : '0;
        rr_d[c]    = rr_q[c];
      end else begin
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < N_NODES; k++) begin
          // Visit nodes rr, rr+1, ... and wrap modulo N_NODES. This also works when N_NODES is not a power of two.
          idx_w = {1'b0, rr_q[c]} + (ID_W + 1)'(k);
          idx_w = (idx_w >= N_NODES_X) ? (idx_w - N_NODES_X) : idx_w;
          idx   = idx_w[ID_W-1:0];
          cand  = req_by_chan_s[c][idx] & ~taken[idx]
                & ~(expire_s[c] & (idx == owner_q[c])) & ~found;
          win   = cand ? idx : win;
          found = found | cand;
        end
        if (found) begin
          valid_d[c] = 1'b1;
          owner_d[c] = win;
          hold_d[c]  = '0;
          rr_d[c]    = (win == ID_LAST) ? '0 : (win + ID_ONE);
          taken[win] = 1'b1;
        end else begin
          valid_d[c] = 1'b0;
          owner_d[c] = '0;
          hold_d[c]  = '0;
          rr_d[c]    = rr_q[c];
        end
      end
    end
  end

  // Build the next control words and per-node grant flags from the next channel state.
  always_comb begin
    control_d = '0;
    grant_d   = '0;
    for (int c = 0; c < N_CHAN; c++) begin
      control_d[c*CW +: CW] = {valid_d[c], owner_d[c]};
      for (int n = 0; n < N_NODES; n++) begin
        grant_d[n*N_CHAN + c] = valid_d[c] & (owner_d[c] == ID_W'(n));
      end
    end
  end

  // State and output registers. Reset drops every ownership at once and rewinds the rr pointers.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q   <= '0;
      control_q <= '0;
      grant_q   <= '0;
      for (int c = 0; c < N_CHAN; c++) begin
        owner_q[c] <= '0;
        hold_q[c]  <= '0;
        rr_q[c]    <= '0;
      end
    end else begin
      valid_q   <= valid_d;
      control_q <= control_d;
      grant_q   <= grant_d;
      for (int c = 0; c < N_CHAN; c++) begin
        owner_q[c] <= owner_d[c];
        hold_q[c]  <= hold_d[c];
        rr_q[c]    <= rr_d[c];
      end
    end
  end

  assign control_port = control_q;
  assign grant_port   = grant_q;

endmodule

// File: tb/tb_multipoint_rr_arbiter.sv
// tb_multipoint_rr_arbiter
// Directed scenarios followed by random traffic. The outputs are compared with
// a behavioural reference model written with integer owners, hold counts and
// modulo round-robin pointers.
module tb_multipoint_rr_arbiter;

  localparam int NN = 8;
  localparam int NC = 4;
  localparam int MH = 4;
  localparam int IW = 3;
  localparam int NB = NN * NC;
  localparam int CB = NC * (IW + 1);

  logic          clk;
  logic          reset;
  logic [NB-1:0] request_port;
  logic [CB-1:0] control_port;
  logic [NB-1:0] grant_port;

  int n_checks;
  int n_fail;

  // Reference model state. An owner of -1 means the channel is idle.
  int m_owner [NC];
  int m_hold  [NC];
  int m_rr    [NC];
  logic [NB-1:0] last_rq;

  multipoint_rr_arbiter #(
    .N_NODES  (NN),
    .N_CHAN   (NC),
    .MAX_HOLD (MH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .request_port (request_port),
    .control_port (control_port),
    .grant_port   (grant_port)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_reset();
    for (int c = 0; c < NC; c++) begin
      m_owner[c] = -1;
      m_hold[c]  = 0;
      m_rr[c]    = 0;
    end
  endfunction

  function automatic void model_step(input logic [NB-1:0] rq, input logic rst);
    bit busy   [NN];
    bit kept   [NC];
    int barred [NC];
    int o;
    int w;
    int n;
    bit rival;
    if (rst) begin
      model_reset();
      return;
    end
    for (int i = 0; i < NN; i++) busy[i] = 1'b0;
    // Current owners either keep their channel or yield it.
    for (int c = 0; c < NC; c++) begin
      kept[c]   = 1'b0;
      barred[c] = -1;
      o = m_owner[c];
      if (o >= 0 && rq[o*NC + c]) begin
        rival = 1'b0;
        for (int i = 0; i < NN; i++) if (i != o && rq[i*NC + c]) rival = 1'b1;
        if (m_hold[c] < MH - 1 || !rival) begin
          kept[c]   = 1'b1;
          busy[o]   = 1'b1;
          m_hold[c] = (m_hold[c] < MH - 1) ? m_hold[c] + 1 : 0;
        end else begin
          barred[c] = o;
        end
      end
    end
    // Free channels, lowest index first, take the first eligible node from the rr pointer.
    for (int c = 0; c < NC; c++) begin
      if (!kept[c]) begin
        w = -1;
        for (int k = 0; k < NN; k++) begin
          n = (m_rr[c] + k) % NN;
          if (w < 0 && rq[n*NC + c] && !busy[n] && n != barred[c]) w = n;
        end
        m_hold[c] = 0;
        if (w >= 0) begin
          m_owner[c] = w;
          m_rr[c]    = (w + 1) % NN;
          busy[w]    = 1'b1;
        end else begin
          m_owner[c] = -1;
        end
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [CB-1:0] ec;
    logic [NB-1:0] eg;
    int cnt;
    int own;
    ec = '0;
    eg = '0;
    for (int c = 0; c < NC; c++) begin
      if (m_owner[c] >= 0) begin
        ec[c*4 +: 4] = {1'b1, 3'(m_owner[c])};
        eg[m_owner[c]*NC + c] = 1'b1;
      end
    end
    n_checks++;
    assert (control_port === ec) else begin
      n_fail++;
      $error("FAIL %s_model_ctl observed=%h expected=%h", tag, control_port, ec);
    end
    n_checks++;
    assert (grant_port === eg) else begin
      n_fail++;
      $error("FAIL %s_model_gnt observed=%h expected=%h", tag, grant_port, eg);
    end
    // Structural invariants that hold whatever the arbitration order is.
    for (int n = 0; n < NN; n++) begin
      cnt = $countones(grant_port[n*NC +: NC]);
      n_checks++;
      assert (cnt <= 1) else begin
        n_fail++;
        $error("FAIL %s_one_grant node=%0d observed=%0d expected<=1", tag, n, cnt);
      end
    end
    for (int c = 0; c < NC; c++) begin
      if (control_port[c*4 + 3] === 1'b1) begin
        own = int'(control_port[c*4 +: 3]);
        n_checks++;
        assert (last_rq[own*NC + c] === 1'b1) else begin
          n_fail++;
          $error("FAIL %s_owner_req ch=%0d owner=%0d observed=0 expected=1", tag, c, own);
        end
      end
    end
  endtask

  // One clock: drive inputs, advance the model at the edge, check 1 time unit later.
  task automatic tick(input logic [NB-1:0] rq, input logic rst, input string tag);
    request_port = rq;
    reset        = rst;
    @(posedge clk);
    model_step(rq, rst);
    last_rq = rq;
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [NB-1:0] rq;
    logic          rst;
    int            mode;
    int            own;
    n_checks     = 0;
    n_fail       = 0;
    reset        = 1'b1;
    request_port = '0;
    last_rq      = '0;
    model_reset();

    // Reset held for two cycles while every node requests everything.
    tick({NB{1'b1}}, 1'b1, "rst_a");
    chk("rst_a_ctl", 32'(control_port), 32'h0000_0000);
    chk("rst_a_gnt", grant_port, 32'h0000_0000);
    tick({NB{1'b1}}, 1'b1, "rst_b");
    chk("rst_b_ctl", 32'(control_port), 32'h0000_0000);
    chk("rst_b_gnt", grant_port, 32'h0000_0000);
    // The first grants appear one cycle after reset is released.
    tick({NB{1'b1}}, 1'b0, "first");
    chk("first_ctl", 32'(control_port), 32'h0000_BA98);
    chk("first_gnt", grant_port, 32'h0000_8421);

    // Node0 wins ch2, so it is not eligible for ch3.
    tick(32'h0000_0000, 1'b1, "rst");
    tick(32'h0000_000C, 1'b0, "n0_ch23");
    chk("n0_ch23_ctl", 32'(control_port), 32'h0000_0800);

    // Four contenders on ch0 rotate, each holding the channel for MAX_HOLD cycles.
    tick(32'h0000_0000, 1'b1, "rst");
    for (int i = 0; i < 20; i++) begin
      tick(32'h0101_0101, 1'b0, "rotate");
      own = ((i / MH) % 4) * 2;
      chk("rotate_ctl", 32'(control_port), 32'(8 + own));
    end

    // A sole requester keeps its channel past the hold limit without a gap.
    tick(32'h0000_0000, 1'b1, "rst");
    for (int i = 0; i < 10; i++) begin
      tick(32'h0020_0000, 1'b0, "sole");
      chk("sole_ctl", 32'(control_port), 32'h0000_00D0);
    end

    // An owner that drops ch0 and requests ch1 wins ch1 in the same cycle.
    tick(32'h0000_0000, 1'b1, "rst");
    tick(32'h0000_0010, 1'b0, "move_a");
    chk("move_a_ctl", 32'(control_port), 32'h0000_0009);
    tick(32'h0000_0020, 1'b0, "move_b");
    chk("move_b_ctl", 32'(control_port), 32'h0000_0090);
    chk("move_b_gnt", grant_port, 32'h0000_0020);

    // Mixed pattern: the nested allocation gives four distinct owners.
    tick(32'h0000_0000, 1'b1, "rst");
    tick(32'h0F0F_0D0E, 1'b0, "mixed");
    chk("mixed_ctl", 32'(control_port), 32'h0000_EC8A);
    chk("mixed_gnt", grant_port, 32'h0804_0102);
    tick(32'h0F0F_0D0E, 1'b0, "mixed_hold");
    tick(32'h0F0F_0D0E, 1'b0, "mixed_hold");
    // A reset in the middle of the bursts clears everything, and arbitration restarts from rr=0.
    tick(32'h0F0F_0D0E, 1'b1, "mid_rst");
    chk("mid_rst_ctl", 32'(control_port), 32'h0000_0000);
    chk("mid_rst_gnt", grant_port, 32'h0000_0000);
    tick(32'h0F0F_0D0E, 1'b0, "replay");
    chk("replay_ctl", 32'(control_port), 32'h0000_EC8A);

    // Random traffic. Requests are often held so that the hold limits are reached.
    rq = '0;
    for (int i = 0; i < 400; i++) begin
      mode = int'($urandom_range(0, 5));
      case (mode)
        0, 1, 2: rq = rq;
        3:       rq = $urandom & $urandom;
        4:       rq = $urandom;
        5:       rq = rq ^ (32'h0000_0001 << $urandom_range(0, 31));
        default: rq = '0;
      endcase
      rst = ($urandom_range(0, 49) == 0);
      tick(rq, rst, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
